// File: rtl/psum_store_ctrl.sv
// Writes one pass of tagged psums from the PE array back to the psum GLB, p innermost then e.
// Optional tag checking is built only when PSUM_STORE_TAG_CHECK_EN is defined.
module psum_store_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_store_start,
  input  logic [5:0]        i_iter_cnt,
  input  logic [4:0]        i_layer_e,
  input  logic [4:0]        i_layer_p,
  input  logic [3:0]        i_layer_s,
  input  logic [DATA_W-1:0] i_psum_data,
  input  logic [7:0]        i_psum_tag,
  input  logic              i_psum_valid,
  output logic              o_psum_ready,
  output logic              o_psum_glb_we,
  output logic [ADDR_W-1:0] o_psum_glb_wa,
  output logic [DATA_W-1:0] o_psum_glb_wd,
  output logic              o_busy,
  output logic              o_store_done,
  output logic              o_tag_err
);

  localparam int AW = (ADDR_W > 17) ? ADDR_W : 17;

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_p_q, cnt_p_d;
  logic [4:0]        cnt_e_q, cnt_e_d;
  logic [4:0]        p_ext, e_ext;
  logic              last_p, last_e, accept, start_pass;
  logic [AW-1:0]     addr_full;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              unused_ok;

  // A zero extent is treated as one beat along that axis.
  assign p_ext      = (i_layer_p == 5'd0) ? 5'd1 : i_layer_p;
  assign e_ext      = (i_layer_e == 5'd0) ? 5'd1 : i_layer_e;
  assign last_p     = (cnt_p_q == 5'(p_ext - 5'd1));
  assign last_e     = (cnt_e_q == 5'(e_ext - 5'd1));
  assign accept     = i_psum_valid & o_psum_ready;
  assign start_pass = (state_q == S_IDLE) & i_store_start;

  assign addr_full = AW'(cnt_p_q) * AW'(e_ext) * AW'(e_ext)
                   + AW'(cnt_e_q) * AW'(e_ext)
                   + AW'(i_iter_cnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_store_start) state_d = S_STORE;
      S_STORE: if (accept && last_p && last_e) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_psum_ready = (state_q == S_STORE);
    o_busy       = (state_q != S_IDLE);
    o_store_done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_p_d = cnt_p_q;
    cnt_e_d = cnt_e_q;
    if (start_pass) begin
      cnt_p_d = 5'd0;
      cnt_e_d = 5'd0;
    end else if (accept) begin
      if (last_p) begin
        cnt_p_d = 5'd0;
        cnt_e_d = last_e ? 5'd0 : 5'(cnt_e_q + 5'd1);
      end else begin
        cnt_p_d = 5'(cnt_p_q + 5'd1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_p_q <= 5'd0;
      cnt_e_q <= 5'd0;
    end else begin
      cnt_p_q <= cnt_p_d;
      cnt_e_q <= cnt_e_d;
    end
  end

  // Address and data hold their last values while no beat is being written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        wa_q <= addr_full[ADDR_W-1:0];
        wd_q <= i_psum_data;
      end
    end
  end

  assign o_psum_glb_we = we_q;
  assign o_psum_glb_wa = wa_q;
  assign o_psum_glb_wd = wd_q;

`ifdef PSUM_STORE_TAG_CHECK_EN
  logic tag_err_q;
  logic tag_bad;

  // Column field carries e+1, wrapping at 16.
  assign tag_bad = (i_psum_tag[7:4] != i_layer_s) ||
                   (i_psum_tag[3:0] != 4'(cnt_e_q[3:0] + 4'd1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_err_q <= 1'b0;
    end else if (start_pass) begin
      tag_err_q <= 1'b0;
    end else if (accept && tag_bad) begin
      tag_err_q <= 1'b1;
    end
  end

  assign o_tag_err = tag_err_q;
  assign unused_ok = ^{addr_full};
`else
  assign o_tag_err = 1'b0;
  assign unused_ok = ^{addr_full, i_layer_s, i_psum_tag};
`endif

endmodule

// File: tb/tb_psum_store_ctrl.sv
// Scoreboard bench for psum_store_ctrl: expected GLB writes are queued at acceptance and checked on output.
module tb_psum_store_ctrl;

  logic        clk;
  logic        i_rst;
  logic        i_store_start;
  logic [5:0]  i_iter_cnt;
  logic [4:0]  i_layer_e;
  logic [4:0]  i_layer_p;
  logic [3:0]  i_layer_s;
  logic [15:0] i_psum_data;
  logic [7:0]  i_psum_tag;
  logic        i_psum_valid;
  logic        o_psum_ready;
  logic        o_psum_glb_we;
  logic [15:0] o_psum_glb_wa;
  logic [15:0] o_psum_glb_wd;
  logic        o_busy;
  logic        o_store_done;
  logic        o_tag_err;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  psum_store_ctrl #(.DATA_W(16), .ADDR_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_store_start (i_store_start),
    .i_iter_cnt    (i_iter_cnt),
    .i_layer_e     (i_layer_e),
    .i_layer_p     (i_layer_p),
    .i_layer_s     (i_layer_s),
    .i_psum_data   (i_psum_data),
    .i_psum_tag    (i_psum_tag),
    .i_psum_valid  (i_psum_valid),
    .o_psum_ready  (o_psum_ready),
    .o_psum_glb_we (o_psum_glb_we),
    .o_psum_glb_wa (o_psum_glb_wa),
    .o_psum_glb_wd (o_psum_glb_wd),
    .o_busy        (o_busy),
    .o_store_done  (o_store_done),
    .o_tag_err     (o_tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One write per queued beat, in the cycle after acceptance; done only with the last one.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!i_rst) begin
      check_eq("we", {31'd0, o_psum_glb_we}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        e = q.pop_front();
        if (o_psum_glb_we) begin
          check_eq("wa", {16'd0, o_psum_glb_wa}, {16'd0, e.addr});
          check_eq("wd", {16'd0, o_psum_glb_wd}, {16'd0, e.data});
        end
        check_eq("done", {31'd0, o_store_done}, {31'd0, e.last});
      end else begin
        check_eq("done_idle", {31'd0, o_store_done}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},    {31'd0, o_psum_glb_we}, 32'd0);
    check_eq({tag, "_wa"},    {16'd0, o_psum_glb_wa}, 32'd0);
    check_eq({tag, "_wd"},    {16'd0, o_psum_glb_wd}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, o_busy},        32'd0);
    check_eq({tag, "_rdy"},   {31'd0, o_psum_ready},  32'd0);
    check_eq({tag, "_done"},  {31'd0, o_store_done},  32'd0);
    check_eq({tag, "_tag"},   {31'd0, o_tag_err},     32'd0);
  endtask

  task automatic run_pass(input int e_in, input int p_in, input int iter, input int s,
                          input bit bubble, input bit poke_start, input int abort_after,
                          input int bad_beat);
    int          eff_e, eff_p, n, to, addr;
    bit          last, tag_bad, tag_exp;
    logic [3:0]  col;
    logic [15:0] d;
    eff_e   = (e_in == 0) ? 1 : e_in;
    eff_p   = (p_in == 0) ? 1 : p_in;
    n       = 0;
    tag_bad = 1'b0;
    i_layer_e  = 5'(e_in);
    i_layer_p  = 5'(p_in);
    i_layer_s  = 4'(s);
    i_iter_cnt = 6'(iter);
    @(posedge clk); #1;
    i_store_start = 1'b1;
    @(posedge clk); #1;
    i_store_start = 1'b0;
    check_eq("busy_start", {31'd0, o_busy}, 32'd1);
    check_eq("tag_clr", {31'd0, o_tag_err}, 32'd0);
    for (int e = 0; e < eff_e; e++) begin
      for (int p = 0; p < eff_p; p++) begin
        d   = 16'($urandom);
        col = 4'(e + ((n == bad_beat) ? 2 : 1));
        i_psum_valid = 1'b1;
        i_psum_data  = d;
        i_psum_tag   = {4'(s), col};
        if (poke_start) i_store_start = 1'b1;
        to = 0;
        @(negedge clk);
        while (!o_psum_ready && to < 20) begin
          @(negedge clk);
          to++;
        end
        if (!o_psum_ready) begin
          check_eq("ready_timeout", 32'd0, 32'd1);
          i_psum_valid  = 1'b0;
          i_store_start = 1'b0;
          return;
        end
        @(posedge clk);
        last = (n == eff_p * eff_e - 1);
        addr = p * eff_e * eff_e + e * eff_e + iter;
        q.push_back('{addr: 16'(addr), data: d, last: last});
        if (n == bad_beat) tag_bad = 1'b1;
        n++;
        #1;
        i_psum_valid = 1'b0;
        if (abort_after != 0 && n == abort_after) begin
          @(negedge clk); #1;
          i_rst = 1'b1;
          #1;
          check_reset_outputs("midrst");
          @(posedge clk);
          @(negedge clk);
          i_rst = 1'b0;
          i_store_start = 1'b0;
          return;
        end
        if (bubble && !last) begin
          @(posedge clk); #1;
        end
      end
    end
    // Now in DONE; a start here must not launch another pass.
    if (poke_start) i_store_start = 1'b1;
`ifdef PSUM_STORE_TAG_CHECK_EN
    tag_exp = tag_bad;
`else
    tag_exp = 1'b0;
`endif
    @(negedge clk);
    check_eq("tag_err_done", {31'd0, o_tag_err}, {31'd0, tag_exp});
    check_eq("busy_done", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #1;
    i_store_start = 1'b0;
    check_eq("busy_idle", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    i_rst = 1'b1;
    i_store_start = 1'b0;
    i_iter_cnt = 6'd0;
    i_layer_e = 5'd0;
    i_layer_p = 5'd0;
    i_layer_s = 4'd0;
    i_psum_data = 16'd0;
    i_psum_tag = 8'd0;
    i_psum_valid = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;

    run_pass(3, 2, 5, 1, 1'b0, 1'b0, 0, -1);
    run_pass(3, 2, 5, 1, 1'b1, 1'b0, 0, -1);
    run_pass(1, 1, 0, 0, 1'b0, 1'b0, 0, -1);
    run_pass(1, 0, 0, 0, 1'b0, 1'b0, 0, -1);
    run_pass(2, 3, 7, 3, 1'b0, 1'b1, 0, -1);

    // Valid offered while idle is never accepted.
    @(posedge clk); #1;
    i_psum_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rdy_idle", {31'd0, o_psum_ready}, 32'd0);
    end
    #1 i_psum_valid = 1'b0;

    run_pass(3, 2, 5, 1, 1'b0, 1'b0, 3, -1);
    repeat (3) @(posedge clk);
    run_pass(3, 2, 5, 1, 1'b0, 1'b0, 0, -1);

    run_pass(2, 1, 0, 2, 1'b0, 1'b0, 0, -1);
    run_pass(2, 1, 0, 2, 1'b0, 1'b0, 0, 1);
    run_pass(2, 1, 0, 2, 1'b1, 1'b0, 0, -1);

    run_pass(0, 2, 3, 0, 1'b1, 1'b0, 0, -1);
    run_pass(5, 4, 63, 15, 1'b0, 1'b0, 0, -1);
    run_pass(31, 31, 63, 4, 1'b0, 1'b0, 0, 40);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("q_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_store_ctrl.md
Name: psum_store_ctrl

Overview:
- Write-side counterpart of the psum load path: accepts tagged psums leaving the PE array over a valid/ready stream and writes them back to the psum GLB.
- Write addresses use the same pass ordering as the load side: p innermost, then e, offset by the iteration count. A load followed by a store with the same layer parameters and iteration count touches identical GLB locations.
- One pass per i_store_start; a one-cycle done pulse signals completion to the top-level controller.

Parameters:
- DATA_W, 16, psum data width.
- ADDR_W, 16, GLB write-address width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_store_start  input  1  start storing one pass; sampled only in IDLE.
- i_iter_cnt  input  6  iteration offset added to the address.
- i_layer_e  input  5  e extent (rows per pass).
- i_layer_p  input  5  p extent.
- i_layer_s  input  4  expected tag row field.
- i_psum_data  input  DATA_W  psum from the PE array.
- i_psum_tag  input  8  psum tag, {row[7:4], col[3:0]}.
- i_psum_valid  input  1  psum beat valid.
- o_psum_ready  output  1  block accepts a beat this cycle.
- o_psum_glb_we  output  1  GLB write enable.
- o_psum_glb_wa  output  ADDR_W  GLB write address.
- o_psum_glb_wd  output  DATA_W  GLB write data.
- o_busy  output  1  high in STORE and DONE.
- o_store_done  output  1  one-cycle pulse when the pass completes.
- o_tag_err  output  1  sticky tag-mismatch flag (see Optional Feature).

Behaviour:
- Reset (async, i_rst=1): state=IDLE, counters cnt_p=cnt_e=0, all outputs 0.
- State machine, states IDLE, STORE, DONE:
  - IDLE -> STORE when i_store_start=1. Counters are cleared on entry.
  - STORE -> DONE on acceptance of the last beat (cnt_p==P-1 and cnt_e==E-1).
  - DONE -> IDLE unconditionally after one cycle.
- i_store_start outside IDLE is ignored and is not queued.
- P = max(i_layer_p, 1) and E = max(i_layer_e, 1). A zero extent is treated as 1.
- Layer inputs and i_iter_cnt must be stable from start until done. They are not latched.
- Handshake: o_psum_ready = (state==STORE), combinational from state only. A beat is accepted when i_psum_valid & o_psum_ready.
  - In IDLE/DONE, valid beats are not accepted; the upstream holds them.
- Per accepted beat:
  - Address = cnt_p*E*E + cnt_e*E + i_iter_cnt, computed in ≥17 bits and truncated to ADDR_W.
  - Counter update: cnt_p increments. At P-1, cnt_p wraps to 0 and cnt_e increments. At E-1, cnt_e wraps to 0.
  - Counters hold in cycles with no accepted beat; bubbles are allowed.
- Write port (1-cycle latency): o_psum_glb_we, wa and wd are registered.
  - we=1 exactly in the cycle after each acceptance, with wa/wd from that beat.
  - When we=0, wa and wd hold their last values.
- Done pulse: o_store_done is high during the DONE cycle. This is the same cycle in which the last GLB write is presented.
- Beat count per pass = P*E exactly.
- o_busy = (state!=IDLE).
- Reset mid-pass: everything returns to reset values immediately. No GLB write occurs in the cycle after reset deassertion. The pass is abandoned and no done pulse is generated.
- o_tag_err is cleared only by reset or by entry to STORE.

Optional Feature:
- Macro PSUM_STORE_TAG_CHECK_EN.
- Defined:
  - Each accepted beat is checked: i_psum_tag[7:4] must equal i_layer_s, and i_psum_tag[3:0] must equal (cnt_e+1) mod 16.
  - On mismatch, o_tag_err is set (registered, visible the cycle after acceptance) and stays set until cleared. The write still occurs.
- Not defined: o_tag_err is tied to 0 and no tag logic is synthesized.

Test Plan:
- E=3, P=2, s=1, iter=5, valid held high: ready for 6 cycles; writes at wa=5,14,8,17,11,20 (p innermost within each e), data in order; o_store_done on the cycle of the 6th write, then IDLE.
- Same configuration with valid toggling 1,0,1,0: same 6 addresses; no write in the cycle after a non-accepting cycle; done only after the 6th accepted beat.
- E=1, P=1, iter=0: single beat written at wa=0; STORE lasts 1 cycle, then DONE then IDLE. i_layer_p=0 behaves identically.
- i_store_start pulsed during STORE and DONE: ignored; exactly one pass of P*E writes; a valid beat offered in IDLE is not accepted (ready=0).
- Assert i_rst after 3 of 6 beats: outputs are 0 asynchronously; no further writes or done; a new start then stores a full pass from wa=iter.
- With PSUM_STORE_TAG_CHECK_EN, E=2, P=1, s=2: tags 0x21, 0x22 leave o_tag_err=0; tag 0x23 on the second beat sets o_tag_err=1, which stays set through DONE and clears on the next start.
